// File: rtl/riskv_pkg.sv
// Shared IF/ID types: the NOP shown while the buffer is empty, the entry record,
// the occupancy classification and instruction register-field helpers.
package riskv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  function automatic logic [4:0] instr_rs1(input logic [XLEN-1:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] instr_rs2(input logic [XLEN-1:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [XLEN-1:0] instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/ifid_fifo_mem.sv
// Entry storage for the IF/ID buffer: DEPTH entries, one synchronous write port
// and one asynchronous read port. Contents are intentionally not reset.
module ifid_fifo_mem
  import riskv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  if_id_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output if_id_entry_t rdata_o
);

  if_id_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifid_buffer.sv
// Elastic IF/ID pipeline buffer: a DEPTH-entry FIFO between fetch and decode with
// registered ready/valid and flush. Define IFID_PERF_EN to add the fetch stall counter.
module ifid_buffer
  import riskv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_F_i,
  output logic                  ready_F_o,
  input  logic [DATA_WIDTH-1:0] Instr_F_i,
  input  logic [DATA_WIDTH-1:0] PC_F_i,
  input  logic [DATA_WIDTH-1:0] PC_Plus4_F_i,
  input  logic                  flush_i,
  output logic                  valid_D_o,
  input  logic                  ready_D_i,
  output logic [DATA_WIDTH-1:0] Instr_D_o,
  output logic [DATA_WIDTH-1:0] PC_D_o,
  output logic [DATA_WIDTH-1:0] PC_Plus4_D_o,
  output logic [4:0]            A1_D_o,
  output logic [4:0]            A2_D_o,
  output logic [4:0]            A3_D_o
`ifdef IFID_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  occ_state_e    occ;
  logic          push, pop;
  if_id_entry_t  wr_entry, head_entry;

  // Occupancy derives only from the registered count, so neither handshake
  // output has a combinational path from the opposite side.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q >= FULL_CNT) begin
      occ = OCC_FULL;
    end
  end

  assign ready_F_o = (occ != OCC_FULL);
  assign valid_D_o = (occ != OCC_EMPTY);

  assign push = valid_F_i && ready_F_o && !flush_i;
  assign pop  = valid_D_o && ready_D_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry.instr    = Instr_F_i;
  assign wr_entry.pc       = PC_F_i;
  assign wr_entry.pc_plus4 = PC_Plus4_F_i;

  ifid_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  // An empty buffer presents a harmless NOP so decode never sees stale storage.
  always_comb begin
    Instr_D_o    = NOP_INSTR;
    PC_D_o       = '0;
    PC_Plus4_D_o = '0;
    if (valid_D_o) begin
      Instr_D_o    = head_entry.instr;
      PC_D_o       = head_entry.pc;
      PC_Plus4_D_o = head_entry.pc_plus4;
    end
  end

  assign A1_D_o = instr_rs1(Instr_D_o);
  assign A2_D_o = instr_rs2(Instr_D_o);
  assign A3_D_o = instr_rd(Instr_D_o);

`ifdef IFID_PERF_EN
  logic [31:0] stall_cnt_q;

  // Counts fetch back-pressure cycles; survives flushes, saturates at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (valid_F_i && !ready_F_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_buffer.sv
// Self-checking bench for ifid_buffer: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the buffer.
module tb_ifid_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_F_i;
  logic          ready_F_o;
  logic [DW-1:0] Instr_F_i;
  logic [DW-1:0] PC_F_i;
  logic [DW-1:0] PC_Plus4_F_i;
  logic          flush_i;
  logic          valid_D_o;
  logic          ready_D_i;
  logic [DW-1:0] Instr_D_o;
  logic [DW-1:0] PC_D_o;
  logic [DW-1:0] PC_Plus4_D_o;
  logic [4:0]    A1_D_o, A2_D_o, A3_D_o;
`ifdef IFID_PERF_EN
  logic [31:0]   stall_cnt_o;
`endif

  ifid_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_F_i    (valid_F_i),
    .ready_F_o    (ready_F_o),
    .Instr_F_i    (Instr_F_i),
    .PC_F_i       (PC_F_i),
    .PC_Plus4_F_i (PC_Plus4_F_i),
    .flush_i      (flush_i),
    .valid_D_o    (valid_D_o),
    .ready_D_i    (ready_D_i),
    .Instr_D_o    (Instr_D_o),
    .PC_D_o       (PC_D_o),
    .PC_Plus4_D_o (PC_Plus4_D_o),
    .A1_D_o       (A1_D_o),
    .A2_D_o       (A2_D_o),
    .A3_D_o       (A3_D_o)
`ifdef IFID_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t        model_q[$];
  int unsigned stall_m;
  int          n_checks;
  int          n_fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs come straight from the model queue: head entry or the NOP.
  task automatic check_outputs(input string ctx);
    logic [31:0] ei, ep, ep4;
    ei  = NOP;
    ep  = '0;
    ep4 = '0;
    if (model_q.size() != 0) begin
      ei  = model_q[0].instr;
      ep  = model_q[0].pc;
      ep4 = model_q[0].pc4;
    end
    check({ctx, ".valid"}, 32'(valid_D_o), 32'(model_q.size() != 0));
    check({ctx, ".ready"}, 32'(ready_F_o), 32'(model_q.size() < DEPTH));
    check({ctx, ".instr"}, Instr_D_o, ei);
    check({ctx, ".pc"},    PC_D_o, ep);
    check({ctx, ".pc4"},   PC_Plus4_D_o, ep4);
    check({ctx, ".a1"},    32'(A1_D_o), 32'(ei[19:15]));
    check({ctx, ".a2"},    32'(A2_D_o), 32'(ei[24:20]));
    check({ctx, ".a3"},    32'(A3_D_o), 32'(ei[11:7]));
`ifdef IFID_PERF_EN
    check({ctx, ".stall"}, stall_cnt_o, stall_m);
`endif
  endtask

  // Called at a falling edge: check, drive, advance the model across one rising edge.
  task automatic cycle(input string ctx, input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic rdy, input logic fl);
    bit   do_push, do_pop;
    ent_t e;
    check_outputs(ctx);
    valid_F_i    = v;
    Instr_F_i    = instr;
    PC_F_i       = pc;
    PC_Plus4_F_i = pc + 32'd4;
    ready_D_i    = rdy;
    flush_i      = fl;
    do_push = v && (model_q.size() < DEPTH) && !fl;
    do_pop  = (model_q.size() != 0) && rdy && !fl;
    if (v && model_q.size() >= DEPTH && stall_m != 32'hFFFF_FFFF) stall_m++;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    stall_m   = 0;
    rst       = 1'b0;
    valid_F_i = 1'b0;
    Instr_F_i = '0;
    PC_F_i    = '0;
    PC_Plus4_F_i = '0;
    ready_D_i = 1'b0;
    flush_i   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;

    // Single push: visible one cycle later with decoded register fields.
    cycle("push1", 1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
    check("push1.a3_direct", 32'(A3_D_o), 32'd1);
    check("push1.pc4_direct", PC_Plus4_D_o, 32'h104);
    cycle("drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, then hold a third instruction against back-pressure.
    cycle("fill_a", 1'b1, 32'h11, 32'h200, 1'b0, 1'b0);
    cycle("fill_b", 1'b1, 32'h22, 32'h204, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("held", 1'b1, 32'h33, 32'h208, 1'b0, 1'b0);
    check("full.ready_direct", 32'(ready_F_o), 32'd0);

    // Full with pop and push offered: pop only, count drops to DEPTH-1.
    cycle("full_pop", 1'b1, 32'h33, 32'h208, 1'b1, 1'b0);
    check("after_pop.ready_direct", 32'(ready_F_o), 32'd1);
    check("after_pop.pc_direct", PC_D_o, 32'h204);
    cycle("refill", 1'b1, 32'h33, 32'h208, 1'b0, 1'b0);

    // Flush while full with a fetch in flight: that fetch must vanish.
    cycle("flush", 1'b1, 32'h44, 32'h20C, 1'b0, 1'b1);
    check("flush.valid_direct", 32'(valid_D_o), 32'd0);
    check("flush.ready_direct", 32'(ready_F_o), 32'd1);
    cycle("post_flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("flush_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Streaming: push and pop together, pointers wrap several times.
    for (int i = 0; i < 8; i++)
      cycle("stream", 1'b1, 32'h0000_0100 + 32'(i), 32'(i * 4), 1'b1, 1'b0);
    cycle("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), $urandom, $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    // Asynchronous reset mid-stream with two entries held.
    cycle("pre_rst_a", 1'b1, 32'h0010_0113, 32'h300, 1'b0, 1'b0);
    cycle("pre_rst_b", 1'b1, 32'h0020_0193, 32'h304, 1'b0, 1'b0);
    check("pre_rst.count2", 32'(model_q.size()), 32'd2);
    valid_F_i = 1'b0;
    ready_D_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst.valid", 32'(valid_D_o), 32'd0);
    check("async_rst.ready", 32'(ready_F_o), 32'd1);
    check("async_rst.instr", Instr_D_o, NOP);
    check("async_rst.pc", PC_D_o, 32'd0);
`ifdef IFID_PERF_EN
    check("async_rst.stall", stall_cnt_o, 32'd0);
`endif
    model_q.delete();
    stall_m = 0;
    @(negedge clk);
    rst = 1'b1;
    cycle("after_rst", 1'b1, 32'h0050_0093, 32'h400, 1'b0, 1'b0);
    cycle("after_rst_chk", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifid_buffer.md
IFID_BUFFER -- requirements
Module: ifid_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction/PC width.
REQ-002 Parameter DEPTH, default 2: entry count, power of two, >=2.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 valid_F_i  in  1  fetch presents an instruction this cycle.
REQ-006 ready_F_o  out  1  buffer accepts a push this cycle.
REQ-007 Instr_F_i  in  DATA_WIDTH  fetched instruction.
REQ-008 PC_F_i  in  DATA_WIDTH  PC of the fetched instruction.
REQ-009 PC_Plus4_F_i  in  DATA_WIDTH  PC+4 of the fetched instruction.
REQ-010 flush_i  in  1  taken branch/jump redirect (PCSrc); discard all contents.
REQ-011 valid_D_o  out  1  head entry valid for decode.
REQ-012 ready_D_i  in  1  decode consumes the head this cycle.
REQ-013 Instr_D_o, PC_D_o, PC_Plus4_D_o  out  DATA_WIDTH each  head entry fields.
REQ-014 A1_D_o, A2_D_o, A3_D_o  out  5 each  Instr_D_o[19:15], [24:20], [11:7].

Function
REQ-015 Push: valid_F_i && ready_F_o && !flush_i writes {Instr, PC, PC_Plus4} at write pointer.
REQ-016 Pop: valid_D_o && ready_D_i && !flush_i advances read pointer.
REQ-017 ready_F_o = (count < DEPTH); depends only on registered count, no combinational path from ready_D_i.
REQ-018 valid_D_o = (count != 0), from registered count only.
REQ-019 Latency: entry pushed in cycle N appears on D outputs with valid_D_o=1 at cycle N+1; no fall-through bypass.
REQ-020 Occupancy states EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); push-only +1, pop-only -1, push+pop unchanged.
REQ-021 Push and pop in same cycle at PARTIAL: both occur; count unchanged; FIFO order kept.
REQ-022 At FULL, push blocked (ready_F_o=0) even if pop occurs that cycle; fetch must hold inputs.
REQ-023 Pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits.
REQ-024 When EMPTY, Instr_D_o = 32'h0000_0013 (addi x0,x0,0), PC_D_o = 0, PC_Plus4_D_o = 0, A*_D_o from that NOP.
REQ-025 flush_i synchronous: next cycle count=0, pointers=0, state EMPTY; same-cycle push and pop ignored.
REQ-026 flush_i while EMPTY: no effect beyond pointer reset.

Reset
REQ-027 rst low asynchronously forces count=0, pointers=0, valid_D_o=0, ready_F_o=1, D outputs to REQ-024 EMPTY values.
REQ-028 Reset mid-operation discards all entries; storage array contents need not be cleared.
REQ-029 First push accepted on first rising edge after rst deasserts.

Configuration
REQ-030 Macro IFID_PERF_EN defined: output stall_cnt_o (32 bits), counting cycles with valid_F_i && !ready_F_o, saturating at 32'hFFFF_FFFF, cleared by rst only (not by flush_i).
REQ-031 Macro IFID_PERF_EN undefined: stall_cnt_o port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared package riskv_pkg holds NOP_INSTR (32'h0000_0013) and the if_id_entry_t struct {instr, pc, pc_plus4}.
REQ-033 One sub-module ifid_fifo_mem: DEPTH x if_id_entry_t register array, one write port, one async read port, no reset.
REQ-034 Pointer, count, flush and handshake logic stay in ifid_buffer.

Verification
REQ-035 Reset: rst low mid-stream with 2 entries -> immediately valid_D_o=0, ready_F_o=1, Instr_D_o=32'h00000013.
REQ-036 Single push: Instr 32'h00500093, PC 32'h100 at cycle N -> cycle N+1 valid_D_o=1, A3_D_o=1, A1_D_o=0, PC_Plus4_D_o=32'h104.
REQ-037 Fill: ready_D_i=0, push 32'h11/32'h22 -> ready_F_o=0; third valid_F_i held; stall_cnt_o increments per cycle (macro on).
REQ-038 Streaming: ready_D_i=1, valid_F_i=1 for 8 cycles PC 0..0x1C -> output order 0..0x1C, no loss/duplication, count stays 1, pointers wrap.
REQ-039 Flush: FULL, flush_i=1 with valid_F_i=1 -> next cycle valid_D_o=0, ready_F_o=1; the flushed-cycle instruction never appears.
REQ-040 FULL with ready_D_i=1 and valid_F_i=1 -> head pops, no push; next cycle count=DEPTH-1, ready_F_o=1.
